router_pkt_tx: RTL

Packet source for the 1x3 router. It accepts a send request (destination, payload length) and buffers the payload bytes. It then drives the router input port with header, payload and parity, using pkt_valid framing and honouring the router's busy back-pressure. It sits at the router input boundary and is the transmit counterpart of the router's input FSM.

---
 rtl/router_pkt_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: buffers a payload, then sends header,
// payload and parity beats with pkt_valid framing under busy back-pressure.
module router_pkt_tx #(
    parameter int unsigned DW = 8,
    parameter int unsigned LW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          start_ready,
    input  logic [1:0]    dest_addr,
    input  logic [LW-1:0] pay_len,
    input  logic [DW-1:0] pl_data,
    input  logic          pl_valid,
    output logic          pl_ready,
    input  logic          busy,
    output logic [DW-1:0] data_out,
    output logic          pkt_valid,
    output logic          done,
    output logic          err
);

    localparam int unsigned DEPTH = 2 ** LW;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] parity_q, parity_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          pkt_valid_q, pkt_valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [DW-1:0] buf_q [DEPTH];
    logic [DW-1:0] header_c;
    logic          we_c;

    assign start_ready = (state_q == IDLE);
    assign pl_ready    = (state_q == LOAD);
    assign data_out    = data_out_q;
    assign pkt_valid   = pkt_valid_q;
    assign done        = done_q;
    assign err         = err_q;

    assign header_c = DW'({len_q, addr_q});
    assign we_c     = (state_q == LOAD) && pl_valid;

    // Payload buffer carries no reset; contents are only read after being written.
    always_ff @(posedge clk) begin
        if (we_c) begin
            buf_q[wr_ptr_q] <= pl_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        parity_d    = parity_q;
        data_out_d  = data_out_q;
        pkt_valid_d = pkt_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((dest_addr == 2'd3) || (pay_len == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d   = dest_addr;
                        len_d    = pay_len;
                        wr_ptr_d = '0;
                        state_d  = LOAD;
                    end
                end
            end
            LOAD: begin
                if (pl_valid) begin
                    wr_ptr_d = wr_ptr_q + LW'(1);
                    if (wr_ptr_q == (len_q - LW'(1))) begin
                        data_out_d  = header_c;
                        pkt_valid_d = 1'b1;
                        parity_d    = header_c;
                        rd_ptr_d    = '0;
                        state_d     = HEADER;
                    end
                end
            end
            HEADER: begin
                if (!busy) begin
                    data_out_d = buf_q[LW'(0)];
                    rd_ptr_d   = LW'(1);
                    state_d    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                // Parity folds in each payload byte as it leaves the bus.
                if (!busy) begin
                    parity_d = parity_q ^ data_out_q;
                    if (rd_ptr_q < len_q) begin
                        data_out_d = buf_q[rd_ptr_q];
                        rd_ptr_d   = rd_ptr_q + LW'(1);
                    end else begin
                        data_out_d  = parity_q ^ data_out_q;
                        pkt_valid_d = 1'b0;
                        state_d     = PARITY;
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    data_out_d = '0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            parity_q    <= '0;
            data_out_q  <= '0;
            pkt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            parity_q    <= parity_d;
            data_out_q  <= data_out_d;
            pkt_valid_q <= pkt_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule
